rf_serial_tx: RTL and testbench

RF_SERIAL_TX -- requirements
Module: rf_serial_tx

---
 rtl/rf_serial_tx.sv | 103 ++++++++++
 tb/tb_rf_serial_tx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_serial_tx.sv
// rf_serial_tx: a small register file whose entries can be read out as
// MSB-first serial frames. A start request snapshots the selected register
// into a shift register, then shifts out DATA_W bits, and finally pulses done.
module rf_serial_tx #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic              start,
  input  logic [ADDR_W-1:0] rAddr,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy,
  output logic              done
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  // Register array: writes land in any FSM state, reset clears every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wAddr] <= wData;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs; sout is forced low outside SHIFT.
  always_comb begin
    state_next = state;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sout       = shreg[DATA_W-1];
        sout_valid = 1'b1;
        busy       = 1'b1;
        if (cnt == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Frame datapath: snapshot on accepted start (old register value wins over a
  // same-edge write), then shift left one bit per cycle while counting bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == IDLE && start) begin
      shreg <= regs[rAddr];
      cnt   <= '0;
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_serial_tx.sv
// tb_rf_serial_tx: directed stimulus pushes expected frames into per-instance
// queues; independent monitors assemble serial bits and compare on each done.
module tb_rf_serial_tx;

  logic        clk;
  logic        reset_n;

  logic        we;
  logic [2:0]  wAddr;
  logic [31:0] wData;
  logic        start;
  logic [2:0]  rAddr;
  logic        sout;
  logic        sout_valid;
  logic        busy;
  logic        done;

  logic        we8;
  logic [2:0]  wAddr8;
  logic [7:0]  wData8;
  logic        start8;
  logic [2:0]  rAddr8;
  logic        sout8;
  logic        sout_valid8;
  logic        busy8;
  logic        done8;

  int          total;
  int          bad;

  logic [31:0] q32 [$];
  logic [7:0]  q8  [$];

  rf_serial_tx #(.DATA_W(32), .ADDR_W(3)) dut32 (
    .clk        (clk),
    .reset_n    (reset_n),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .start      (start),
    .rAddr      (rAddr),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  rf_serial_tx #(.DATA_W(8), .ADDR_W(3)) dut8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .we         (we8),
    .wAddr      (wAddr8),
    .wData      (wData8),
    .start      (start8),
    .rAddr      (rAddr8),
    .sout       (sout8),
    .sout_valid (sout_valid8),
    .busy       (busy8),
    .done       (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor for the 32-bit instance: gather bits, compare the frame on done.
  logic [31:0] acc32;
  int          bits32;
  always @(negedge clk) begin
    if (!reset_n) begin
      acc32  = '0;
      bits32 = 0;
    end else begin
      if (!sout_valid) begin
        check("sout_idle_zero", 64'(sout), 64'd0);
      end else begin
        check("busy_with_valid", 64'(busy), 64'd1);
        acc32  = {acc32[30:0], sout};
        bits32++;
      end
      if (done) begin
        check("done_busy_low", 64'(busy), 64'd0);
        if (q32.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done32: got frame 0x%0h want no frame", acc32);
        end else begin
          check("frame32", 64'(acc32), 64'(q32.pop_front()));
          check("bits32", 64'(bits32), 64'd32);
        end
        acc32  = '0;
        bits32 = 0;
      end
    end
  end

  // Monitor for the 8-bit instance.
  logic [7:0] acc8;
  int         bits8;
  always @(negedge clk) begin
    if (!reset_n) begin
      acc8  = '0;
      bits8 = 0;
    end else begin
      if (!sout_valid8) begin
        check("sout8_idle_zero", 64'(sout8), 64'd0);
      end else begin
        acc8  = {acc8[6:0], sout8};
        bits8++;
      end
      if (done8) begin
        if (q8.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done8: got frame 0x%0h want no frame", acc8);
        end else begin
          check("frame8", 64'(acc8), 64'(q8.pop_front()));
          check("bits8", 64'(bits8), 64'd8);
        end
        acc8  = '0;
        bits8 = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [31:0] data);
    we    = 1'b1;
    wAddr = addr;
    wData = data;
    tick();
    we    = 1'b0;
  endtask

  task automatic start_frame(input logic [2:0] addr, input logic [31:0] expv);
    q32.push_back(expv);
    start = 1'b1;
    rAddr = addr;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done32(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got no done within 200 cycles want done", name);
    end
  endtask

  task automatic finish_frame32(input string name);
    wait_done32(name);
    tick();
  endtask

  // Directed scenarios.
  initial begin
    int nbusy;
    int gap;
    bit seen;
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    we = 1'b0; wAddr = '0; wData = '0; start = 1'b0; rAddr = '0;
    we8 = 1'b0; wAddr8 = '0; wData8 = '0; start8 = 1'b0; rAddr8 = '0;

    // Reset state, with we/start asserted that must be ignored.
    tick();
    we = 1'b1; wAddr = 3'd7; wData = 32'hFFFF_FFFF; start = 1'b1; rAddr = 3'd7;
    tick();
    tick();
    check("reset_sout", 64'(sout), 64'd0);
    check("reset_valid", 64'(sout_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    we = 1'b0; start = 1'b0;
    reset_n = 1'b1;
    tick();
    start_frame(3'd7, 32'h0000_0000);
    finish_frame32("reset_ignore_we");

    // Basic frame, busy length and single done pulse.
    write_reg(3'd2, 32'hA500_0001);
    start_frame(3'd2, 32'hA500_0001);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
    check("busy_cycles", 64'(nbusy), 64'd32);
    @(negedge clk);
    check("done_single", 64'(done), 64'd0);
    tick();

    // Write during a frame does not disturb it.
    write_reg(3'd0, 32'hFFFF_FFFF);
    start_frame(3'd0, 32'hFFFF_FFFF);
    repeat (5) tick();
    write_reg(3'd0, 32'h0000_0000);
    finish_frame32("snapshot_frame");
    start_frame(3'd0, 32'h0000_0000);
    finish_frame32("snapshot_readback");

    // Same-edge write and start to the same register.
    write_reg(3'd3, 32'h8000_0000);
    we = 1'b1; wAddr = 3'd3; wData = 32'h0000_0001;
    start = 1'b1; rAddr = 3'd3;
    q32.push_back(32'h8000_0000);
    tick();
    we = 1'b0; start = 1'b0;
    finish_frame32("same_edge_old");
    start_frame(3'd3, 32'h0000_0001);
    finish_frame32("same_edge_new");

    // Start pulses during SHIFT and DONE are dropped.
    write_reg(3'd4, 32'h1234_5678);
    start_frame(3'd4, 32'h1234_5678);
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    tick();
    check("done_latency", 64'(done), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("no_queued_frame", 64'(busy), 64'd0);

    // Start held high: back-to-back frames with a two-cycle gap.
    write_reg(3'd5, 32'hCAFE_F00D);
    q32.push_back(32'hCAFE_F00D);
    q32.push_back(32'hCAFE_F00D);
    start = 1'b1;
    rAddr = 3'd5;
    tick();
    wait_done32("held_first");
    gap = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      gap++;
      if (sout_valid) seen = 1'b1;
    end
    check("restart_gap", 64'(gap), 64'd2);
    start = 1'b0;
    finish_frame32("held_second");

    // Reset mid-frame aborts with no done, then every register reads 0.
    write_reg(3'd1, 32'h0F0F_0F0F);
    start = 1'b1;
    rAddr = 3'd1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    reset_n = 1'b0;
    #1;
    check("abort_sout", 64'(sout), 64'd0);
    check("abort_valid", 64'(sout_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      start_frame(3'(i), 32'h0000_0000);
      finish_frame32("post_reset_read");
    end

    // Narrow instance: 8-bit frame of 0x3C.
    we8 = 1'b1; wAddr8 = 3'd7; wData8 = 8'h3C;
    tick();
    we8 = 1'b0;
    q8.push_back(8'h3C);
    start8 = 1'b1; rAddr8 = 3'd7;
    tick();
    start8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    check("done8_seen", 64'(seen), 64'd1);

    repeat (5) tick();
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench cannot hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
